// File: rtl/kbuf_pkg.sv
// Shared constants for the Kanalog buffer serial chain.
// The counter width rule, reset values and error-count ceiling live here so the top and bench agree.
`timescale 1ns/1ps
package kbuf_pkg;
  localparam int               MAX_W         = 64;
  localparam logic [MAX_W-1:0] ISR_RESET     = '1;
  localparam logic             DAC_CLK_RESET = 1'b1;
  localparam logic [7:0]       ERR_SAT       = 8'd255;

  // Wide enough for 0..OUT_BITS+1, where OUT_BITS+1 marks an overrun frame.
  function automatic int cnt_w(input int out_bits);
    return $clog2(out_bits + 2);
  endfunction
endpackage

// File: rtl/kbuf_chain_if.sv
// JP7 serial pins plus the board-side parallel words of the Kanalog buffer chain.
// master = KFLOP/board side driving the pins; slave = the chain engine.
`timescale 1ns/1ps
interface kbuf_chain_if #(
  parameter int OUT_BITS = 24,
  parameter int IN_BITS  = 16
);
  logic                sclk_in;
  logic                latch_in;
  logic                sdi;
  logic [IN_BITS-1:0]  p_in;
  logic                sdo;
  logic [OUT_BITS-1:0] par_out;
  logic                out_valid;
  logic                frame_err;
  logic [7:0]          err_count;
  logic                dac_clk;

  modport master (
    output sclk_in, latch_in, sdi, p_in,
    input  sdo, par_out, out_valid, frame_err, err_count, dac_clk
  );

  modport slave (
    input  sclk_in, latch_in, sdi, p_in,
    output sdo, par_out, out_valid, frame_err, err_count, dac_clk
  );
endinterface

// File: rtl/kbuf_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin, followed by an edge detector
// whose rise/fall pulses are registered (pin edge to pulse = SYNC_STAGES+1 clk).
`timescale 1ns/1ps
module kbuf_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic clr,
  input  logic async_in,
  output logic sync_out,
  output logic rise,
  output logic fall
);
  wire [SYNC_STAGES:0] chain;
  logic edge_reg;
  logic rise_reg;
  logic fall_reg;

  assign chain[0] = async_in;

  for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
    logic stage_reg;
    always_ff @(posedge clk or posedge clr) begin
      if (clr) stage_reg <= 1'b0;
      else     stage_reg <= chain[gi];
    end
    assign chain[gi+1] = stage_reg;
  end

  assign sync_out = chain[SYNC_STAGES];

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      edge_reg <= 1'b0;
      rise_reg <= 1'b0;
      fall_reg <= 1'b0;
    end else begin
      edge_reg <= sync_out;
      rise_reg <= sync_out & ~edge_reg;
      fall_reg <= ~sync_out & edge_reg;
    end
  end

  assign rise = rise_reg;
  assign fall = fall_reg;
endmodule

// File: rtl/kbuf_chain.sv
// KFLOP JP7 serial chain engine: serial-to-parallel output word, parallel-to-serial input word,
// regenerated DAC clock. Frame bit-count checking is built only when KBUF_FRAME_CHECK_EN is defined.
`timescale 1ns/1ps
module kbuf_chain
  import kbuf_pkg::*;
#(
  parameter int OUT_BITS    = 24,
  parameter int IN_BITS     = 16,
  parameter int SYNC_STAGES = 2
) (
  input logic         clk,
  input logic         clr,
  kbuf_chain_if.slave bus
);
  logic sck_rise, sck_fall, lat_rise, lat_fall, sdi_s;
  logic unused_sck_lvl, unused_lat_lvl, unused_sdi_rise, unused_sdi_fall;

  kbuf_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sck (
    .clk(clk), .clr(clr), .async_in(bus.sclk_in),
    .sync_out(unused_sck_lvl), .rise(sck_rise), .fall(sck_fall)
  );

  kbuf_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_lat (
    .clk(clk), .clr(clr), .async_in(bus.latch_in),
    .sync_out(unused_lat_lvl), .rise(lat_rise), .fall(lat_fall)
  );

  kbuf_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sdi (
    .clk(clk), .clr(clr), .async_in(bus.sdi),
    .sync_out(sdi_s), .rise(unused_sdi_rise), .fall(unused_sdi_fall)
  );

  // Parallel inputs only need level synchronisation; they are sampled on the latch fall.
  wire [IN_BITS-1:0] p_chain [SYNC_STAGES+1];
  assign p_chain[0] = bus.p_in;

  for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_psync
    logic [IN_BITS-1:0] stage_reg;
    always_ff @(posedge clk or posedge clr) begin
      if (clr) stage_reg <= '0;
      else     stage_reg <= p_chain[gi];
    end
    assign p_chain[gi+1] = stage_reg;
  end

  logic [OUT_BITS-1:0] osr_reg, osr_next, par_out_reg;
  logic [IN_BITS-1:0]  isr_reg, isr_shift;
  logic                out_valid_reg, dac_clk_reg, frame_ok;

  // A coincident latch sees the post-shift register, so capture from osr_next.
  always_comb begin
    osr_next = osr_reg;
    if (sck_rise) osr_next = {osr_reg[OUT_BITS-2:0], sdi_s};
  end

  if (IN_BITS == 1) begin : g_isr_one
    assign isr_shift = 1'b1;
  end else begin : g_isr_wide
    assign isr_shift = {isr_reg[IN_BITS-2:0], 1'b1};
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      osr_reg       <= '0;
      par_out_reg   <= '0;
      out_valid_reg <= 1'b0;
      isr_reg       <= ISR_RESET[IN_BITS-1:0];
      dac_clk_reg   <= DAC_CLK_RESET;
    end else begin
      out_valid_reg <= 1'b0;
      osr_reg       <= osr_next;
      if (lat_rise && frame_ok) begin
        par_out_reg   <= osr_next;
        out_valid_reg <= 1'b1;
      end
      // Load beats shift when latch and Dclk fall together.
      if (lat_fall)      isr_reg <= p_chain[SYNC_STAGES];
      else if (sck_fall) isr_reg <= isr_shift;
      if (lat_rise)      dac_clk_reg <= 1'b0;
      else if (lat_fall) dac_clk_reg <= 1'b1;
    end
  end

`ifdef KBUF_FRAME_CHECK_EN
  localparam int CNT_W = cnt_w(OUT_BITS);

  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             frame_err_reg;
  logic [7:0]       err_count_reg;

  always_comb begin
    cnt_next = cnt_reg;
    if (sck_rise && (cnt_reg != CNT_W'(OUT_BITS + 1))) cnt_next = cnt_reg + 1'b1;
  end

  assign frame_ok = (cnt_next == CNT_W'(OUT_BITS));

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt_reg       <= '0;
      frame_err_reg <= 1'b0;
      err_count_reg <= '0;
    end else begin
      frame_err_reg <= 1'b0;
      cnt_reg       <= lat_rise ? '0 : cnt_next;
      if (lat_rise && !frame_ok) begin
        frame_err_reg <= 1'b1;
        if (err_count_reg != ERR_SAT) err_count_reg <= err_count_reg + 8'd1;
      end
    end
  end

  assign bus.frame_err = frame_err_reg;
  assign bus.err_count = err_count_reg;
`else
  assign frame_ok      = 1'b1;
  assign bus.frame_err = 1'b0;
  assign bus.err_count = '0;
`endif

  assign bus.sdo       = isr_reg[IN_BITS-1];
  assign bus.par_out   = par_out_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.dac_clk   = dac_clk_reg;
endmodule

// File: tb/tb_kbuf_chain.sv
// Directed + randomised bench for kbuf_chain against a frame-level reference model.
// Follows KBUF_FRAME_CHECK_EN so the expected accept/reject rule matches the build.
`timescale 1ns/1ps
module tb_kbuf_chain;
  localparam int OB = 24;
  localparam int IB = 16;
  localparam int SS = 2;
  localparam logic [63:0] OMASK = (64'd1 << OB) - 64'd1;
  localparam logic [63:0] IMASK = (64'd1 << IB) - 64'd1;
`ifdef KBUF_FRAME_CHECK_EN
  localparam bit FC = 1'b1;
`else
  localparam bit FC = 1'b0;
`endif

  logic clk = 1'b0;
  logic clr = 1'b1;
  int   errors = 0;
  int   checks = 0;

  // Reference model: bits seen since the last latch, last accepted word, error count, input word.
  logic [63:0] m_osr, m_par, m_isr;
  int          m_cnt, m_err;
  logic        m_dac;

  kbuf_chain_if #(.OUT_BITS(OB), .IN_BITS(IB)) bus ();

  kbuf_chain #(.OUT_BITS(OB), .IN_BITS(IB), .SYNC_STAGES(SS)) dut (
    .clk(clk),
    .clr(clr),
    .bus(bus)
  );

  always #7.5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reset();
    m_osr = '0; m_cnt = 0; m_par = '0; m_err = 0; m_isr = IMASK; m_dac = 1'b1;
  endtask

  task automatic model_shift_in(input logic b);
    m_osr = ((m_osr << 1) | {63'b0, b}) & OMASK;
    if (m_cnt < OB + 1) m_cnt++;
  endtask

  task automatic send_bit(input logic b);
    bus.sdi = b;
    wait_clk(2);
    bus.sclk_in = 1'b1;
    model_shift_in(b);
    wait_clk(4);
    bus.sclk_in = 1'b0;
    m_isr = ((m_isr << 1) | 64'd1) & IMASK;
    wait_clk(4);
    check("sdo_bit", {63'b0, bus.sdo}, {63'b0, m_isr[IB-1]});
  endtask

  task automatic send_frame(input int n, input logic [63:0] d);
    for (int i = n - 1; i >= 0; i--) send_bit(d[i]);
  endtask

  // Latch pulse; with_clk makes the final Dclk edges coincide with the latch edges.
  task automatic latch_cycle(input bit with_clk, input logic b, input logic [IB-1:0] pin,
                             input string tag);
    int ov_n, fe_n, ov_at, fe_at;
    bit acc;
    ov_n = 0; fe_n = 0; ov_at = 0; fe_at = 0;
    bus.p_in = pin;
    if (with_clk) begin
      bus.sdi = b;
      wait_clk(2);
    end else begin
      wait_clk(SS + 1);
    end
    check({tag, "_dac_idle"}, {63'b0, bus.dac_clk}, {63'b0, m_dac});
    bus.latch_in = 1'b1;
    if (with_clk) begin
      bus.sclk_in = 1'b1;
      model_shift_in(b);
    end
    acc = !FC || (m_cnt == OB);
    if (acc) m_par = m_osr;
    else if (m_err < 255) m_err++;
    m_cnt = 0;
    m_dac = 1'b0;
    for (int k = 1; k <= SS + 4; k++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) begin ov_n++; ov_at = k; end
      if (bus.frame_err === 1'b1) begin fe_n++; fe_at = k; end
    end
    check({tag, "_ov_n"}, 64'(ov_n), acc ? 64'd1 : 64'd0);
    check({tag, "_ov_at"}, 64'(ov_at), acc ? 64'(SS + 2) : 64'd0);
    check({tag, "_fe_n"}, 64'(fe_n), acc ? 64'd0 : 64'd1);
    check({tag, "_fe_at"}, 64'(fe_at), acc ? 64'd0 : 64'(SS + 2));
    check({tag, "_par"}, 64'(bus.par_out), m_par);
    check({tag, "_errcnt"}, 64'(bus.err_count), 64'(m_err));
    check({tag, "_dac_lo"}, {63'b0, bus.dac_clk}, 64'd0);
    bus.latch_in = 1'b0;
    if (with_clk) bus.sclk_in = 1'b0;
    m_isr = {48'b0, pin};
    m_dac = 1'b1;
    wait_clk(SS + 4);
    check({tag, "_dac_hi"}, {63'b0, bus.dac_clk}, 64'd1);
    check({tag, "_sdo_load"}, {63'b0, bus.sdo}, {63'b0, m_isr[IB-1]});
    $display("frame %s accepted=%0b par_out=0x%0h err_count=%0d", tag, acc, bus.par_out,
             bus.err_count);
  endtask

  initial begin
    logic [63:0] d;
    int len;
    bus.sclk_in = 1'b0; bus.latch_in = 1'b0; bus.sdi = 1'b0; bus.p_in = '0;
    clr = 1'b1;
    model_reset();
    wait_clk(3);
    clr = 1'b0;
    wait_clk(2);
    check("rst_par", 64'(bus.par_out), 64'd0);
    check("rst_sdo", {63'b0, bus.sdo}, 64'd1);
    check("rst_dac", {63'b0, bus.dac_clk}, 64'd1);
    check("rst_err", 64'(bus.err_count), 64'd0);
    check("rst_ov", {63'b0, bus.out_valid}, 64'd0);
    check("rst_fe", {63'b0, bus.frame_err}, 64'd0);

    // Good frame, then short and long frames.
    send_frame(24, 64'hA5C33C);
    latch_cycle(1'b0, 1'b0, 16'($urandom), "good");
    send_frame(23, {$urandom, $urandom});
    latch_cycle(1'b0, 1'b0, 16'($urandom), "short");
    send_frame(25, {$urandom, $urandom});
    latch_cycle(1'b0, 1'b0, 16'($urandom), "long");

    // Input readback of 0x8001 over 18 Dclk, all trailing bits return 1.
    latch_cycle(1'b0, 1'b0, 16'h8001, "rb_load");
    send_frame(18, {$urandom, $urandom});
    latch_cycle(1'b0, 1'b0, 16'($urandom), "rb_end");

    // Asynchronous reset in the middle of a frame.
    send_frame(5, {$urandom, $urandom});
    @(negedge clk);
    #3 clr = 1'b1;
    #1;
    model_reset();
    check("mid_rst_par", 64'(bus.par_out), 64'd0);
    check("mid_rst_sdo", {63'b0, bus.sdo}, 64'd1);
    check("mid_rst_dac", {63'b0, bus.dac_clk}, 64'd1);
    check("mid_rst_err", 64'(bus.err_count), 64'd0);
    @(negedge clk);
    clr = 1'b0;
    wait_clk(2);
    send_frame(24, {$urandom, $urandom});
    latch_cycle(1'b0, 1'b0, 16'($urandom), "post_rst");

    // Final Dclk edges coincide with latch edges.
    d = {$urandom, $urandom};
    send_frame(23, d >> 1);
    latch_cycle(1'b1, d[0], 16'($urandom), "coinc");
    send_frame(24, {$urandom, $urandom});
    latch_cycle(1'b0, 1'b0, 16'($urandom), "coinc_rb");

    // Random frame lengths around the nominal width.
    for (int i = 0; i < 8; i++) begin
      len = ($urandom_range(0, 1) == 1) ? OB : int'($urandom_range(OB - 3, OB + 3));
      send_frame(len, {$urandom, $urandom});
      latch_cycle(1'b0, 1'b0, 16'($urandom), $sformatf("rand%0d_len%0d", i, len));
    end

    // Error-count saturation with empty frames.
    for (int i = 0; i < 300; i++) latch_cycle(1'b0, 1'b0, 16'($urandom), "sat");
    check("sat_final", 64'(bus.err_count), FC ? 64'd255 : 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/kbuf_chain.md
# kbuf_chain

Parametrised serial output/input chain engine for the KFLOP Kanalog buffer FPGA. It receives the KFLOP JP7 digital/DAC serial stream (`Dclk`, `Dlatch`, `Ddout`) and presents it as an OUT_BITS-wide latched parallel word. In the same frame it shifts an IN_BITS-wide parallel input snapshot back out on `Ddin`. Compared with the fixed 8/16/24-bit chains, it adds configurable widths, configurable synchroniser depth, frame bit-count checking with error reporting, and a regenerated DAC clock. It sits between the JP7 pins and the board-level output latches and input buffers.

## Interface
- OUT_BITS, 24: serial-to-parallel output word width, 2..64.
- IN_BITS, 16: parallel-to-serial input word width, 1..64.
- SYNC_STAGES, 2: synchroniser flops per asynchronous input, 2..4.
- clk  in  1: fabric clock (66.5 MHz OSCH); sole clock.
- clr  in  1: reset, asynchronous, active-high (driven from `~kreset`).
- sclk_in  in  1: async serial clock (`Dclk`).
- latch_in  in  1: async frame latch (`Dlatch`).
- sdi  in  1: async serial data in (`Ddout`).
- p_in  in  IN_BITS: async parallel inputs (Kanalog inputs).
- sdo  out  1: serial data returned to KFLOP (`Ddin`).
- par_out  out  OUT_BITS: latched output word.
- out_valid  out  1: one-clk pulse when `par_out` updates.
- frame_err  out  1: one-clk pulse on a rejected frame.
- err_count  out  8: saturating rejected-frame count.
- dac_clk  out  1: regenerated DAC clock, the inverse of the synchronised latch.

## Operation
- Each of sclk_in, latch_in and sdi passes through SYNC_STAGES flops, then one edge-detect flop. This yields the pulses sck_rise, sck_fall, lat_rise and lat_fall. sdi_s is the synchronised sdi.
- Output path on sck_rise: `osr <= {osr[OUT_BITS-2:0], sdi_s}`. bit_cnt increments and saturates at OUT_BITS+1 (overrun).
- Output path on lat_rise, frame accepted (bit_cnt == OUT_BITS):
  - `par_out <= osr`, out_valid pulses.
- Output path on lat_rise, frame rejected (bit_cnt != OUT_BITS):
  - `par_out` holds, frame_err pulses.
  - err_count increments, saturating at 255.
  - bit_cnt clears in both the accepted and rejected cases.
- Input path on lat_fall: `isr <= p_in`, sampled through SYNC_STAGES flops.
- Input path on sck_fall: `isr <= {isr[IN_BITS-2:0], 1'b1}`. `sdo = isr[IN_BITS-1]`.
- Shifting beyond IN_BITS returns 1s.
- dac_clk: cleared on lat_rise, set on lat_fall, otherwise held.
- Simultaneous sck_rise and lat_rise in the same clk:
  - The shift is applied first.
  - The latch compares and captures the post-shift osr and count.
  - bit_cnt ends at 0.
- Simultaneous sck_fall and lat_fall: the load wins and the shift is discarded.
- Reset (asynchronous, any time, including mid-frame):
  - osr, par_out and bit_cnt clear to 0.
  - out_valid, frame_err and err_count clear to 0.
  - isr is set to all 1s, so sdo = 1.
  - dac_clk = 1.
  - All synchroniser and edge flops clear to 0.
  - A partial frame is discarded.

## Timing
- Pin edge to internal pulse: SYNC_STAGES+1 clk cycles.
- `par_out`/out_valid/frame_err: registered, valid 1 clk after lat_rise.
- Pin-to-output total: SYNC_STAGES+2 clk cycles.
- sdo changes 1 clk after sck_fall. KFLOP samples it on its next Dclk rise.
- Minimum Dclk high or low time: SYNC_STAGES+1 clk periods (about 45 ns at SYNC_STAGES=2). Shorter pulses are undefined.
- Latch must not rise sooner than SYNC_STAGES+2 clk after the final Dclk rise. Otherwise the last bit is counted against the next frame.
- `p_in` must be stable for SYNC_STAGES clk before latch falls.

## Configuration
- `KBUF_FRAME_CHECK_EN` defined:
  - Bit counting and rejection are active as described above.
- Undefined:
  - bit_cnt logic is removed.
  - Every lat_rise loads `par_out` and pulses out_valid.
  - frame_err is tied 0 and err_count is tied 0.

## Structure
- Package `kbuf_pkg`:
  - Width rule `CNT_W = $clog2(OUT_BITS+2)`.
  - Reset constants: `ISR_RESET` all-ones, `DAC_CLK_RESET` = 1.
  - Error-count saturation value 255.
- One sub-module, `kbuf_sync_edge`:
  - Parameter SYNC_STAGES.
  - Ports: clk, clr, async_in; outputs sync_out, rise, fall.
  - Three instances: sclk_in, latch_in and sdi; sdi uses only sync_out.
- `p_in` uses a vector synchroniser inside the top.

## Test plan
- Reset: assert clr mid-frame after 5 Dclk.
  - Required: par_out=0, sdo=1, dac_clk=1, err_count=0 immediately.
  - Required: the next full frame is accepted.
- Good frame (OUT_BITS=24): shift 0xA5C33C MSB-first, then latch.
  - Required: par_out=0xA5C33C and one out_valid pulse SYNC_STAGES+2 clk after the latch pin rises.
  - Required: dac_clk low while latch is high.
- Short and long frames: 23 Dclk then latch, then 25 Dclk then latch.
  - Required: par_out holds the previous value, two frame_err pulses, err_count=2.
  - Without `KBUF_FRAME_CHECK_EN`: par_out updates and err_count stays 0.
- Input readback (IN_BITS=16): p_in=0x8001, latch falls, then 18 Dclk.
  - Required: sdo sequence 1,0×14,1,1,1.
- Coincidence: drive the final Dclk rise and latch rise on the same pin edge.
  - Required: the 24th bit is captured and the frame is accepted.
  - Drive the Dclk fall and latch fall together: required isr = p_in, no shift.
- Saturation: 300 short frames.
  - Required: err_count=255 and holds.
